// File: rtl/scaled_view_addr_gen_if.sv
// Framebuffer read port plus the copier reload handshake of scaled_view_addr_gen.
// Handshake: reload_req is a one-cycle request pulse driven by the generator; the copier answers with
// reload_done (level or pulse) once the framebuffer holds the image for the new view. The read port has
// no backpressure: ram_q carries the data for the ram_rdaddr presented RD_LAT cycles earlier.
interface scaled_view_addr_gen_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [PIX_W-1:0]  ram_q;
  logic              reload_req;
  logic              reload_done;

  modport master (output ram_rdaddr, output reload_req, input ram_q, input reload_done);
  modport slave  (input ram_rdaddr, input reload_req, output ram_q, output reload_done);
endinterface

// File: rtl/scaled_view_addr_gen.sv
// scaled_view_addr_gen: centres a 1x / zoomed-in / zoomed-out source image in the VGA raster and turns
// raster coordinates into framebuffer read addresses, returning colour RD_LAT+2 cycles after each
// coordinate. New configurations are applied only at frame start and are followed by a copier reload.
// Optional build macro SCALED_VIEW_BORDER_EN adds a one-pixel BORDER_COLOR frame around the view.
module scaled_view_addr_gen #(
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 120,
  parameter int DISP_W   = 640,
  parameter int DISP_H   = 480,
  parameter int CRD_W    = 10,
  parameter int ADDR_W   = 19,
  parameter int PIX_W    = 8,
  parameter int MAX_LOG2 = 2,
  parameter int RD_LAT   = 1
`ifdef SCALED_VIEW_BORDER_EN
  ,
  parameter logic [PIX_W-1:0] BORDER_COLOR = PIX_W'(8'hFF)
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CRD_W-1:0]       next_x,
  input  logic [CRD_W-1:0]       next_y,
  input  logic [1:0]             mode,
  input  logic [1:0]             zoom_log2,
  scaled_view_addr_gen_if.master bus,
  output logic [1:0]             active_mode,
  output logic [1:0]             active_log2,
  output logic                   cfg_err,
  output logic                   busy,
  output logic [PIX_W-1:0]       color_out,
  output logic [1:0]             dbg_state
);

  // Internal geometry is carried at 16 bits so view sizes and offset sums never wrap.
  localparam int CW = 16;
  typedef logic [CW-1:0] crd_t;
  localparam crd_t SRC_WC  = crd_t'(SRC_W);
  localparam crd_t SRC_HC  = crd_t'(SRC_H);
  localparam crd_t DISP_WC = crd_t'(DISP_W);
  localparam crd_t DISP_HC = crd_t'(DISP_H);

  typedef enum logic [1:0] {
    S_DISPLAY = 2'd0,
    S_PEND    = 2'd1,
    S_RELOAD  = 2'd2,
    S_WAITF   = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic              apply;
  logic              reload_req_r;
  logic [ADDR_W-1:0] rdaddr;
  crd_t              view_w, view_h, xoff, yoff;
  crd_t              x, y, dx, dy, cand_w, cand_h, req_w, req_h;
  logic [1:0]        req_mode, req_log2;
  logic              req_err, cfg_diff, frame_start, in_view;
  logic [ADDR_W-1:0] addr_calc;
  logic [RD_LAT:0]   iv_pipe;

  assign x           = crd_t'(next_x);
  assign y           = crd_t'(next_y);
  assign frame_start = (next_x == '0) && (next_y == '0);
  assign busy        = (state == S_RELOAD) || (state == S_WAITF);
  assign dbg_state   = state;
  assign bus.reload_req = reload_req_r;
  assign bus.ram_rdaddr = rdaddr;

  // Legalise the requested configuration; identity modes are normalised to mode 00 with k=0.
  always_comb begin
    cand_w   = SRC_WC;
    cand_h   = SRC_HC;
    req_mode = 2'b00;
    req_log2 = 2'b00;
    req_err  = 1'b0;
    req_w    = SRC_WC;
    req_h    = SRC_HC;
    if (mode == 2'b01) begin
      cand_w = SRC_WC << zoom_log2;
      cand_h = SRC_HC << zoom_log2;
    end else if (mode == 2'b10) begin
      cand_w = SRC_WC >> zoom_log2;
      cand_h = SRC_HC >> zoom_log2;
    end
    if ((zoom_log2 > 2'(MAX_LOG2)) || (cand_w > DISP_WC) || (cand_h > DISP_HC) ||
        (cand_w == '0) || (cand_h == '0)) begin
      req_err = 1'b1;
    end else if ((mode == 2'b01) || (mode == 2'b10)) begin
      req_mode = mode;
      req_log2 = zoom_log2;
      req_w    = cand_w;
      req_h    = cand_h;
    end
    cfg_diff = (req_mode != active_mode) || (req_log2 != active_log2) || (req_err != cfg_err);
  end

  // Next-state logic; apply marks the frame start at which the pending config becomes active.
  always_comb begin
    state_nx = state;
    apply    = 1'b0;
    case (state)
      S_DISPLAY: if (cfg_diff) state_nx = S_PEND;
      S_PEND: begin
        if (frame_start) begin
          if (cfg_diff) begin
            apply    = 1'b1;
            state_nx = S_RELOAD;
          end else begin
            state_nx = S_DISPLAY;
          end
        end else if (!cfg_diff) begin
          state_nx = S_DISPLAY;
        end
      end
      S_RELOAD: if (bus.reload_done) state_nx = S_WAITF;
      S_WAITF:  if (frame_start) state_nx = cfg_diff ? S_PEND : S_DISPLAY;
      default:  state_nx = S_DISPLAY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_DISPLAY;
    else       state <= state_nx;
  end

  // Displayed configuration and centring offsets; they only move when a config is applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_mode  <= 2'b00;
      active_log2  <= 2'b00;
      cfg_err      <= 1'b0;
      view_w       <= SRC_WC;
      view_h       <= SRC_HC;
      xoff         <= (DISP_WC - SRC_WC) >> 1;
      yoff         <= (DISP_HC - SRC_HC) >> 1;
      reload_req_r <= 1'b0;
    end else begin
      reload_req_r <= apply;
      if (apply) begin
        active_mode <= req_mode;
        active_log2 <= req_log2;
        cfg_err     <= req_err;
        view_w      <= req_w;
        view_h      <= req_h;
        xoff        <= (DISP_WC - req_w) >> 1;
        yoff        <= (DISP_HC - req_h) >> 1;
      end
    end
  end

  // View membership and linear address of the current coordinate.
  always_comb begin
    dx        = x - xoff;
    dy        = y - yoff;
    in_view   = (x < DISP_WC) && (y < DISP_HC) &&
                (x >= xoff) && (x < xoff + view_w) && (y >= yoff) && (y < yoff + view_h);
    addr_calc = ADDR_W'(dy) * ADDR_W'(view_w) + ADDR_W'(dx);
  end

  // Address register plus the in_view delay line that lines up with ram_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdaddr  <= '0;
      iv_pipe <= '0;
    end else begin
      rdaddr     <= in_view ? addr_calc : '0;
      iv_pipe[0] <= in_view;
      for (int i = 1; i <= RD_LAT; i++) iv_pipe[i] <= iv_pipe[i-1];
    end
  end

`ifdef SCALED_VIEW_BORDER_EN
  logic            on_border;
  logic [RD_LAT:0] bd_pipe;
  localparam crd_t ONE = crd_t'(1);

  // Ring one pixel outside the view, clipped to the visible display.
  always_comb begin
    on_border = !in_view && (x < DISP_WC) && (y < DISP_HC) &&
                (x + ONE >= xoff) && (x <= xoff + view_w) &&
                (y + ONE >= yoff) && (y <= yoff + view_h);
  end

  // Border flag delay line, same latency as image pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd_pipe <= '0;
    end else begin
      bd_pipe[0] <= on_border;
      for (int i = 1; i <= RD_LAT; i++) bd_pipe[i] <= bd_pipe[i-1];
    end
  end
`endif

  // Output colour: image pixel while displaying, border ring if built, otherwise black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_out <= '0;
    end else if (iv_pipe[RD_LAT] && !busy) begin
      color_out <= bus.ram_q;
`ifdef SCALED_VIEW_BORDER_EN
    end else if (bd_pipe[RD_LAT]) begin
      color_out <= BORDER_COLOR;
`endif
    end else begin
      color_out <= '0;
    end
  end

endmodule
